// File: rtl/approx_add_pipe_if.sv
// ---------------------------------------------------------------------------
// approx_add_pipe_if
// Operand/result handshake bundle for the pipelined approximate adder.
//   in_valid / in_ready      : operand beat handshake (producer -> adder)
//   in_a, in_b               : WIDTH-bit operands
//   in_cin                   : carry-in
//   in_approx_en             : 1 = approximate LSB cells active for this beat
//   out_valid / out_ready    : result handshake (adder -> consumer)
//   out_sum, out_cout        : WIDTH-bit sum and carry-out
// The 'master' modport is the side that produces operands and consumes
// results; the 'slave' modport is the adder itself.
// ---------------------------------------------------------------------------
interface approx_add_pipe_if #(
   parameter int WIDTH = 16
) ();

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             in_cin;
   logic             in_approx_en;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_sum;
   logic             out_cout;

   modport master (
      output in_valid, in_a, in_b, in_cin, in_approx_en, out_ready,
      input  in_ready, out_valid, out_sum, out_cout
   );

   modport slave (
      input  in_valid, in_a, in_b, in_cin, in_approx_en, out_ready,
      output in_ready, out_valid, out_sum, out_cout
   );

endinterface

// File: rtl/approx_add_pipe.sv
// ---------------------------------------------------------------------------
// approx_add_pipe
// Pipelined approximate adder. The N_APPROX least-significant bit cells may
// use the approximate cell (sum = a|b, cout = a&b, carry-in ignored) when the
// beat's approx_en is set; all other cells are exact full adders. The carry
// chain is split into CHUNK-bit stages, one register stage per chunk, so the
// latency is WIDTH/CHUNK cycles with one beat per cycle throughput.
//
// Ports:
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset, clears every in-flight beat
//   bus      : approx_add_pipe_if.slave (operand and result handshakes)
//   err_clr  : clears err_cnt (wins over a same-cycle increment)
//   err_cnt  : 16-bit saturating count of results differing from exact sum
//
// Optional feature macro: APPROX_ADD_ERR_STAT_EN
//   defined   : an exact sum travels alongside each beat and err_cnt counts
//               delivered results that differ from it
//   undefined : no exact path, err_cnt is tied to 0 and err_clr is ignored
// ---------------------------------------------------------------------------
module approx_add_pipe #(
   parameter int WIDTH    = 16,
   parameter int N_APPROX = 4,
   parameter int CHUNK    = 4
) (
   input  logic             clk,
   input  logic             rst,
   approx_add_pipe_if.slave bus,
   input  logic             err_clr,
   output logic [15:0]      err_cnt
);

   localparam int STAGES = WIDTH / CHUNK;
   localparam int LAST   = STAGES - 1;

   logic [WIDTH-1:0] a_q       [STAGES];
   logic [WIDTH-1:0] b_q       [STAGES];
   logic [WIDTH-1:0] sum_q     [STAGES];
   logic             carry_q   [STAGES];
   logic             apx_q     [STAGES];
   logic             valid_q   [STAGES];

   logic [WIDTH-1:0] a_d       [STAGES];
   logic [WIDTH-1:0] b_d       [STAGES];
   logic [WIDTH-1:0] sum_d     [STAGES];
   logic             carry_d   [STAGES];
   logic             apx_d     [STAGES];
   logic             valid_d   [STAGES];
   logic [WIDTH-1:0] prevSum   [STAGES];
   logic             prevCarry [STAGES];
   logic [CHUNK:0]   chunkRes  [STAGES];

   logic adv;

   // Resolves one CHUNK-bit slice starting at bit 'base'. Returns {cout, sum}.
   // A cell is approximate only when the beat asks for it and the absolute
   // bit index lies inside the approximate LSB region.
   function automatic logic [CHUNK:0] addChunk(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic             cin,
                                               input logic             apx,
                                               input int               base);
      logic [CHUNK-1:0] aS;
      logic [CHUNK-1:0] bS;
      logic [CHUNK-1:0] s;
      logic             c;
      aS = CHUNK'(a >> base);
      bS = CHUNK'(b >> base);
      s  = '0;
      c  = cin;
      for (int j = 0; j < CHUNK; j++) begin
         if (apx && (base + j < N_APPROX)) begin
            s[j] = aS[j] | bS[j];
            c    = aS[j] & bS[j];
         end else begin
            s[j] = aS[j] ^ bS[j] ^ c;
            c    = (aS[j] & bS[j]) | (c & (aS[j] ^ bS[j]));
         end
      end
      return {c, s};
   endfunction

   // The whole pipe moves together; it only stalls when a finished result is
   // sitting at the output and the consumer is not taking it.
   assign adv           = !valid_q[LAST] || bus.out_ready;
   assign bus.in_ready  = adv;
   assign bus.out_valid = valid_q[LAST];
   assign bus.out_sum   = sum_q[LAST];
   assign bus.out_cout  = carry_q[LAST];

   // Stage k takes its operands from the bus (k = 0) or from stage k-1 and
   // ORs its freshly resolved chunk into the partial sum it inherited.
   generate
      for (genvar k = 0; k < STAGES; k++) begin : gStage
         if (k == 0) begin : gHead
            assign a_d[k]       = bus.in_a;
            assign b_d[k]       = bus.in_b;
            assign apx_d[k]     = bus.in_approx_en;
            assign valid_d[k]   = bus.in_valid;
            assign prevSum[k]   = '0;
            assign prevCarry[k] = bus.in_cin;
         end else begin : gBody
            assign a_d[k]       = a_q[k-1];
            assign b_d[k]       = b_q[k-1];
            assign apx_d[k]     = apx_q[k-1];
            assign valid_d[k]   = valid_q[k-1];
            assign prevSum[k]   = sum_q[k-1];
            assign prevCarry[k] = carry_q[k-1];
         end
         assign chunkRes[k] = addChunk(a_d[k], b_d[k], prevCarry[k], apx_d[k], k * CHUNK);
         assign sum_d[k]    = prevSum[k] | (WIDTH'(chunkRes[k][CHUNK-1:0]) << (k * CHUNK));
         assign carry_d[k]  = chunkRes[k][CHUNK];
      end
   endgenerate

   // Stage registers. Stage 0 loads in_valid directly: since it only loads
   // when adv (= in_ready) is high, a bubble is captured whenever no beat is
   // accepted, and bubbles then ride through like ordinary beats.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < STAGES; k++) begin
            valid_q[k] <= 1'b0;
            sum_q[k]   <= '0;
            carry_q[k] <= 1'b0;
            a_q[k]     <= '0;
            b_q[k]     <= '0;
            apx_q[k]   <= 1'b0;
         end
      end else if (adv) begin
         for (int k = 0; k < STAGES; k++) begin
            valid_q[k] <= valid_d[k];
            sum_q[k]   <= sum_d[k];
            carry_q[k] <= carry_d[k];
            a_q[k]     <= a_d[k];
            b_q[k]     <= b_d[k];
            apx_q[k]   <= apx_d[k];
         end
      end
   end

`ifdef APPROX_ADD_ERR_STAT_EN
   logic [WIDTH-1:0] exSum_q     [STAGES];
   logic             exCarry_q   [STAGES];
   logic [WIDTH-1:0] exSum_d     [STAGES];
   logic             exCarry_d   [STAGES];
   logic [WIDTH-1:0] prevExSum   [STAGES];
   logic             prevExCarry [STAGES];
   logic [CHUNK:0]   exRes       [STAGES];
   logic [15:0]      errCnt_q;
   logic             mismatch;

   // Shadow exact adder: same operands, every cell exact, real carry-in.
   generate
      for (genvar k = 0; k < STAGES; k++) begin : gExact
         if (k == 0) begin : gHead
            assign prevExSum[k]   = '0;
            assign prevExCarry[k] = bus.in_cin;
         end else begin : gBody
            assign prevExSum[k]   = exSum_q[k-1];
            assign prevExCarry[k] = exCarry_q[k-1];
         end
         assign exRes[k]     = addChunk(a_d[k], b_d[k], prevExCarry[k], 1'b0, k * CHUNK);
         assign exSum_d[k]   = prevExSum[k] | (WIDTH'(exRes[k][CHUNK-1:0]) << (k * CHUNK));
         assign exCarry_d[k] = exRes[k][CHUNK];
      end
   endgenerate

   // Exact-path registers advance in lockstep with the main pipeline.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < STAGES; k++) begin
            exSum_q[k]   <= '0;
            exCarry_q[k] <= 1'b0;
         end
      end else if (adv) begin
         for (int k = 0; k < STAGES; k++) begin
            exSum_q[k]   <= exSum_d[k];
            exCarry_q[k] <= exCarry_d[k];
         end
      end
   end

   assign mismatch = {carry_q[LAST], sum_q[LAST]} != {exCarry_q[LAST], exSum_q[LAST]};

   // Mismatch counter: counts only delivered results, saturates at all-ones,
   // and a clear in the same cycle as an increment wins.
   always_ff @(posedge clk) begin
      if (rst) begin
         errCnt_q <= '0;
      end else if (err_clr) begin
         errCnt_q <= '0;
      end else if (valid_q[LAST] && bus.out_ready && mismatch && (errCnt_q != 16'hFFFF)) begin
         errCnt_q <= errCnt_q + 16'd1;
      end
   end

   assign err_cnt = errCnt_q;
`else
   // Statistics not built: the counter reads zero and the clear is a no-op.
   logic unusedErrClr;
   assign unusedErrClr = err_clr;
   assign err_cnt      = '0;
`endif

endmodule

// File: tb/tb_approx_add_pipe.sv
// ---------------------------------------------------------------------------
// tb_approx_add_pipe
// Self-checking bench for approx_add_pipe (WIDTH=16, N_APPROX=4, CHUNK=4).
// A negedge monitor keeps a queue of expected results built from a plain
// arithmetic reference of the approximate adder and checks every delivered
// result and the error counter; the main sequence adds directed checks for
// latency, throughput, backpressure, reset and counter behaviour.
// ---------------------------------------------------------------------------
module tb_approx_add_pipe;

   localparam int WIDTH    = 16;
   localparam int N_APPROX = 4;
   localparam int CHUNK    = 4;
   localparam int STAGES   = WIDTH / CHUNK;

`ifdef APPROX_ADD_ERR_STAT_EN
   localparam bit STAT_EN = 1'b1;
`else
   localparam bit STAT_EN = 1'b0;
`endif

   typedef struct {
      logic [15:0] sum;
      logic        cout;
      logic        mism;
   } expT;

   logic        clk    = 1'b0;
   logic        rst    = 1'b1;
   logic        errClr = 1'b0;
   logic [15:0] errCnt;

   int          checks = 0;
   int          errors = 0;
   int          cyc    = 0;
   bit          armed  = 1'b0;
   logic [15:0] expErr = '0;
   expT         expQ[$];

   approx_add_pipe_if #(.WIDTH(WIDTH)) bus ();

   approx_add_pipe #(
      .WIDTH    (WIDTH),
      .N_APPROX (N_APPROX),
      .CHUNK    (CHUNK)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus),
      .err_clr (errClr),
      .err_cnt (errCnt)
   );

   // Free-running clock and a cycle index used for latency measurements.
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Single comparison point: counts the check and reports a mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference adder at word level: the approximate region is a bitwise OR
   // whose top AND feeds an ordinary integer add of the upper part.
   function automatic logic [16:0] refAdd(input logic [15:0] a, input logic [15:0] b,
                                          input logic cin, input logic apx);
      int unsigned low, upper, c, mask;
      if (apx && N_APPROX > 0) begin
         mask  = (32'd1 << N_APPROX) - 32'd1;
         low   = 32'(a | b) & mask;
         c     = (32'(a & b) >> (N_APPROX - 1)) & 32'd1;
         upper = (32'(a) >> N_APPROX) + (32'(b) >> N_APPROX) + c;
         return 17'((upper << N_APPROX) | low);
      end
      return {1'b0, a} + {1'b0, b} + 17'(cin);
   endfunction

   // Advance to just after the next rising edge, where inputs are driven.
   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   // Offers one beat (called just after a rising edge) and returns just after
   // the edge that accepted it, with in_valid dropped.
   task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b,
                                input logic cin, input logic apx);
      bit done;
      done             = 1'b0;
      bus.in_a         = a;
      bus.in_b         = b;
      bus.in_cin       = cin;
      bus.in_approx_en = apx;
      bus.in_valid     = 1'b1;
      for (int n = 0; n < 60 && !done; n++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            @(posedge clk);
            #1;
            done = 1'b1;
         end
      end
      bus.in_valid = 1'b0;
      checkOutput("accept_in_time", 32'(done), 1);
   endtask

   // Sends one beat with the output open and checks latency and value.
   task automatic runDirected(input string tag, input logic [15:0] a, input logic [15:0] b,
                              input logic cin, input logic apx,
                              input logic [15:0] expSum, input logic expCout);
      int n;
      bus.out_ready = 1'b1;
      applyStimulus(a, b, cin, apx);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.out_valid && n < 20);
      checkOutput({tag, "_latency"}, 32'(n), STAGES);
      checkOutput({tag, "_sum"}, 32'(bus.out_sum), 32'(expSum));
      checkOutput({tag, "_cout"}, 32'(bus.out_cout), 32'(expCout));
      stepCycle();
   endtask

   // Scoreboard: results leaving on a handshake are compared in order against
   // the queue; accepted beats are modelled and queued; the counter model
   // follows clear-over-increment and saturation. Reset drops everything.
   always @(negedge clk) begin
      expT         e;
      logic [16:0] r;
      logic [16:0] ex;
      logic [15:0] nextErr;
      if (rst) begin
         armed  = 1'b1;
         expErr = '0;
         expQ.delete();
      end else if (armed) begin
         checkOutput("err_cnt", 32'(errCnt), 32'(expErr));
         nextErr = expErr;
         if (bus.out_valid && bus.out_ready) begin
            checkOutput("out_expected", 32'(expQ.size() > 0), 1);
            if (expQ.size() > 0) begin
               e = expQ.pop_front();
               checkOutput("out_sum", 32'(bus.out_sum), 32'(e.sum));
               checkOutput("out_cout", 32'(bus.out_cout), 32'(e.cout));
               if (STAT_EN && e.mism && nextErr != 16'hFFFF) nextErr = nextErr + 16'd1;
            end
         end
         if (errClr) nextErr = '0;
         expErr = nextErr;
         if (bus.in_valid && bus.in_ready) begin
            r      = refAdd(bus.in_a, bus.in_b, bus.in_cin, bus.in_approx_en);
            ex     = refAdd(bus.in_a, bus.in_b, bus.in_cin, 1'b0);
            e.sum  = r[15:0];
            e.cout = r[16];
            e.mism = (r != ex);
            expQ.push_back(e);
         end
      end
   end

   // Main directed and random sequence.
   initial begin
      int   firstAcc, firstVal, lastVal, valCnt, startCyc;
      bit   held;
      logic [15:0] heldSum;
      logic        heldCout;
      bit          expOutValid;

      bus.in_valid     = 1'b0;
      bus.in_a         = '0;
      bus.in_b         = '0;
      bus.in_cin       = 1'b0;
      bus.in_approx_en = 1'b0;
      bus.out_ready    = 1'b1;

      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("rst_out_valid", 32'(bus.out_valid), 0);
      checkOutput("rst_out_sum", 32'(bus.out_sum), 0);
      checkOutput("rst_out_cout", 32'(bus.out_cout), 0);
      checkOutput("rst_in_ready", 32'(bus.in_ready), 1);
      checkOutput("rst_err_cnt", 32'(errCnt), 0);
      stepCycle();

      runDirected("apx_mode", 16'h000F, 16'h0001, 1'b0, 1'b1, 16'h000F, 1'b0);
      @(negedge clk);
      checkOutput("err_first", 32'(errCnt), STAT_EN ? 1 : 0);
      stepCycle();
      runDirected("exact_mode", 16'h000F, 16'h0001, 1'b0, 1'b0, 16'h0010, 1'b0);
      runDirected("exact_cout", 16'hFFFF, 16'h0001, 1'b1, 1'b0, 16'h0001, 1'b1);
      runDirected("apx_cin_ignored", 16'hFFFF, 16'h0001, 1'b1, 1'b1, 16'hFFFF, 1'b0);
      repeat (3) stepCycle();

      // Throughput: eight back-to-back beats must emerge on eight consecutive
      // cycles, the first one ready to be consumed at edge t+STAGES.
      firstAcc = 0;
      firstVal = -1;
      lastVal  = 0;
      valCnt   = 0;
      fork
         begin
            for (int i = 0; i < 8; i++) begin
               applyStimulus(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
               if (i == 0) firstAcc = cyc;
            end
         end
         begin
            repeat (30) begin
               @(negedge clk);
               if (bus.out_valid) begin
                  if (firstVal < 0) firstVal = cyc;
                  lastVal = cyc;
                  valCnt++;
               end
            end
         end
      join
      checkOutput("tp_latency", 32'(firstVal - firstAcc), STAGES - 1);
      checkOutput("tp_count", 32'(valCnt), 8);
      checkOutput("tp_contiguous", 32'(lastVal - firstVal), 7);
      stepCycle();

      // Backpressure: with the output blocked the pipe fills after STAGES
      // beats, in_ready drops as out_valid rises, and the output holds.
      bus.out_ready = 1'b0;
      held          = 1'b0;
      heldSum       = '0;
      heldCout      = 1'b0;
      startCyc      = cyc;
      fork
         begin
            for (int i = 0; i < 6; i++) begin
               applyStimulus(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
            end
         end
         begin
            repeat (14) begin
               @(negedge clk);
               expOutValid = (cyc - startCyc) >= STAGES;
               checkOutput("bp_out_valid", 32'(bus.out_valid), 32'(expOutValid));
               checkOutput("bp_in_ready", 32'(bus.in_ready), 32'(!expOutValid));
               if (bus.out_valid) begin
                  if (!held) begin
                     held     = 1'b1;
                     heldSum  = bus.out_sum;
                     heldCout = bus.out_cout;
                  end else begin
                     checkOutput("bp_sum_hold", 32'(bus.out_sum), 32'(heldSum));
                     checkOutput("bp_cout_hold", 32'(bus.out_cout), 32'(heldCout));
                  end
               end
            end
            stepCycle();
            bus.out_ready = 1'b1;
         end
      join
      repeat (12) stepCycle();
      @(negedge clk);
      checkOutput("bp_seen_valid", 32'(held), 1);
      checkOutput("bp_drained", 32'(expQ.size()), 0);
      stepCycle();

      // Reset with three beats in flight: none of them may ever appear.
      bus.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      end
      rst = 1'b1;
      stepCycle();
      rst = 1'b0;
      @(negedge clk);
      checkOutput("midrst_out_valid", 32'(bus.out_valid), 0);
      checkOutput("midrst_out_sum", 32'(bus.out_sum), 0);
      checkOutput("midrst_in_ready", 32'(bus.in_ready), 1);
      repeat (10) begin
         @(negedge clk);
         checkOutput("midrst_no_ghost", 32'(bus.out_valid), 0);
      end
      stepCycle();

      // Random traffic with random stalls, bubbles and occasional clears.
      for (int i = 0; i < 400; i++) begin
         bus.in_valid     = ($urandom_range(3, 0) != 0);
         bus.in_a         = 16'($urandom);
         bus.in_b         = 16'($urandom);
         bus.in_cin       = 1'($urandom);
         bus.in_approx_en = 1'($urandom);
         bus.out_ready    = ($urandom_range(3, 0) != 0);
         errClr           = ($urandom_range(31, 0) == 0);
         stepCycle();
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      errClr        = 1'b0;
      repeat (10) stepCycle();
      @(negedge clk);
      checkOutput("rand_drained", 32'(expQ.size()), 0);
      stepCycle();

      // Saturation: far more mismatching beats than the counter can hold.
      for (int i = 0; i < 70000; i++) begin
         applyStimulus(16'h000F, 16'h0001, 1'b0, 1'b1);
      end
      repeat (8) stepCycle();
      @(negedge clk);
      checkOutput("err_saturated", 32'(errCnt), STAT_EN ? 32'hFFFF : 0);
      stepCycle();

      // Clear coinciding with a mismatching result: the clear wins.
      applyStimulus(16'h000F, 16'h0001, 1'b0, 1'b1);
      for (int n = 0; n < 20 && !bus.out_valid; n++) stepCycle();
      errClr = 1'b1;
      stepCycle();
      errClr = 1'b0;
      @(negedge clk);
      checkOutput("err_clr_priority", 32'(errCnt), 0);
      stepCycle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Guard against a hung handshake.
   initial begin
      #(10 * 200000);
      $display("[TB] FAIL watchdog: got no completion, expected finish within 200000 cycles");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
